// File: rtl/filter_coef_ctrl_pkg.sv
// Shared types and defaults for the filter coefficient controller.
`timescale 1ns/1ps
package filter_ctrl_pkg;

  localparam int NR_STAGES_DEF = 32;
  localparam int DWIDTH_DEF    = 16;

  // Index width for a bank of n taps; a single-tap bank still needs one bit.
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    C_IDLE,
    C_ACK,
    C_WAIT
  } cfg_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_ACK,
    S_REL,
    S_SWAP
  } smp_state_e;

endpackage

// File: rtl/filter_coef_ctrl_if.sv
// Host-side 4-phase configuration port of the coefficient controller.
`timescale 1ns/1ps
interface filter_coef_ctrl_if import filter_ctrl_pkg::*; #(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = addr_width(NR_STAGES_DEF)
);
    logic                     cfg_req;
    logic                     cfg_ack;
    logic                     cfg_commit;
    logic [AWIDTH-1:0]        cfg_addr;
    logic signed [DWIDTH-1:0] cfg_data;
    logic                     cfg_err;

    modport master (
        output cfg_req, cfg_commit, cfg_addr, cfg_data,
        input  cfg_ack, cfg_err
    );

    modport slave (
        input  cfg_req, cfg_commit, cfg_addr, cfg_data,
        output cfg_ack, cfg_err
    );
endinterface

// File: rtl/filter_coef_ctrl_coef_bank.sv
// Shadow/active coefficient banks; tap 0 occupies the most significant DWIDTH bits of h_o.
`timescale 1ns/1ps
module coef_bank import filter_ctrl_pkg::*; #(
    parameter int NR_STAGES = NR_STAGES_DEF,
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int AWIDTH    = addr_width(NR_STAGES),
    parameter int CWIDTH    = NR_STAGES * DWIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [AWIDTH-1:0]        wr_addr_i,
    input  logic signed [DWIDTH-1:0] wr_data_i,
    input  logic                     swap_i,
    output logic [CWIDTH-1:0]        h_o
);

    logic signed [DWIDTH-1:0] shadow_q [NR_STAGES];
    logic signed [DWIDTH-1:0] active_q [NR_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_STAGES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR_STAGES; i++) begin
                if (wr_en_i && (int'(wr_addr_i) == i)) begin
                    shadow_q[i] <= wr_data_i;
                end
            end
            if (swap_i) begin
                active_q <= shadow_q;
            end
        end
    end

    for (genvar g = 0; g < NR_STAGES; g++) begin : g_pack
        assign h_o[CWIDTH-1-g*DWIDTH -: DWIDTH] = active_q[g];
    end

endmodule

// File: rtl/filter_coef_ctrl.sv
// Coefficient bank controller: host config FSM plus sample handshake FSM that swaps banks only between transfers.
`timescale 1ns/1ps
module filter_coef_ctrl import filter_ctrl_pkg::*; #(
    parameter int NR_STAGES = NR_STAGES_DEF,
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int CWIDTH    = NR_STAGES * DWIDTH,
    parameter int AWIDTH    = addr_width(NR_STAGES)
) (
    input  logic                clk,
    input  logic                rst,
    filter_coef_ctrl_if.slave   cfg,
    input  logic                flt_in_req,
    output logic                flt_in_ack,
    output logic                src_req,
    input  logic                src_ack,
    output logic [CWIDTH-1:0]   h_out,
    output logic [7:0]          swap_cnt
);

    cfg_state_e cst_q, cst_d;
    smp_state_e sst_q, sst_d;

    logic       cfg_ack_q, cfg_ack_d;
    logic       cfg_err_q, cfg_err_d;
    logic       pend_q, pend_d;
    logic       src_req_q, src_req_d;
    logic       flt_ack_q, flt_ack_d;
    logic [7:0] swap_cnt_q, swap_cnt_d;

    logic wr_en;
    logic pend_set;
    logic swap_stb;
    logic addr_ok;

    assign swap_stb = (sst_q == S_SWAP);
    assign addr_ok  = (int'(cfg.cfg_addr) < NR_STAGES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cst_q      <= C_IDLE;
            sst_q      <= S_IDLE;
            cfg_ack_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            pend_q     <= 1'b0;
            src_req_q  <= 1'b0;
            flt_ack_q  <= 1'b0;
            swap_cnt_q <= 8'd0;
        end else begin
            cst_q      <= cst_d;
            sst_q      <= sst_d;
            cfg_ack_q  <= cfg_ack_d;
            cfg_err_q  <= cfg_err_d;
            pend_q     <= pend_d;
            src_req_q  <= src_req_d;
            flt_ack_q  <= flt_ack_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    // Config FSM: writes land only in C_IDLE, so the shadow bank is frozen while a commit waits.
    always_comb begin
        cst_d     = cst_q;
        cfg_ack_d = cfg_ack_q;
        cfg_err_d = cfg_err_q;
        wr_en     = 1'b0;
        pend_set  = 1'b0;
        case (cst_q)
            C_IDLE: begin
                if (cfg.cfg_req) begin
                    if (cfg.cfg_commit) begin
                        pend_set = 1'b1;
                        cst_d    = C_WAIT;
                    end else begin
                        cfg_ack_d = 1'b1;
                        cst_d     = C_ACK;
                        if (addr_ok) begin
                            wr_en = 1'b1;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
            end
            C_WAIT: begin
                if (swap_stb) begin
                    cfg_ack_d = 1'b1;
                    cst_d     = C_ACK;
                end
            end
            C_ACK: begin
                if (!cfg.cfg_req) begin
                    cfg_ack_d = 1'b0;
                    cst_d     = C_IDLE;
                end
            end
            default: cst_d = C_IDLE;
        endcase
    end

    assign pend_d = (pend_q & ~swap_stb) | pend_set;

    // Sample FSM: a pending swap wins over a new request, and no request starts until src_ack has dropped.
    always_comb begin
        sst_d      = sst_q;
        src_req_d  = src_req_q;
        flt_ack_d  = flt_ack_q;
        swap_cnt_d = swap_cnt_q;
        case (sst_q)
            S_IDLE: begin
                if (pend_q) begin
                    sst_d = S_SWAP;
                end else if (flt_in_req) begin
                    src_req_d = 1'b1;
                    sst_d     = S_FWD;
                end
            end
            S_FWD: begin
                if (src_ack) begin
                    flt_ack_d = 1'b1;
                    sst_d     = S_ACK;
                end
            end
            S_ACK: begin
                if (!flt_in_req) begin
                    flt_ack_d = 1'b0;
                    src_req_d = 1'b0;
                    sst_d     = S_REL;
                end
            end
            S_REL: begin
                if (!src_ack) begin
                    sst_d = pend_q ? S_SWAP : S_IDLE;
                end
            end
            S_SWAP: begin
                swap_cnt_d = swap_cnt_q + 8'd1;
                sst_d      = S_IDLE;
            end
            default: sst_d = S_IDLE;
        endcase
    end

    coef_bank #(
        .NR_STAGES (NR_STAGES),
        .DWIDTH    (DWIDTH),
        .AWIDTH    (AWIDTH),
        .CWIDTH    (CWIDTH)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (cfg.cfg_addr),
        .wr_data_i (cfg.cfg_data),
        .swap_i    (swap_stb),
        .h_o       (h_out)
    );

    assign cfg.cfg_ack = cfg_ack_q;
    assign cfg.cfg_err = cfg_err_q;
    assign src_req     = src_req_q;
    assign flt_in_ack  = flt_ack_q;
    assign swap_cnt    = swap_cnt_q;

endmodule

// File: tb/tb_filter_coef_ctrl.sv
// Bench for filter_coef_ctrl: vector table, handshake corner sequences, randomized traffic against a bank model.
`timescale 1ns/1ps
module tb_filter_coef_ctrl;

    localparam int NS = 32;
    localparam int DW = 16;
    localparam int AW = 6;
    localparam int CW = NS * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          flt_in_req;
    logic          flt_in_ack;
    logic          src_req;
    logic          src_ack;
    logic [CW-1:0] h_out;
    logic [7:0]    swap_cnt;

    int checks   = 0;
    int failures = 0;

    // Model of what the host has written and committed.
    int model_shadow [NS];
    int model_active [NS];
    int model_swaps;
    bit model_err;

    typedef struct {
        bit commit;
        int addr;
        int data;
        int exp_lat;
        bit exp_err;
        int exp_swaps;
    } vec_t;

    vec_t vecs [9];

    filter_coef_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) cfg ();

    filter_coef_ctrl #(
        .NR_STAGES (NS),
        .DWIDTH    (DW),
        .AWIDTH    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg        (cfg),
        .flt_in_req (flt_in_req),
        .flt_in_ack (flt_in_ack),
        .src_req    (src_req),
        .src_ack    (src_ack),
        .h_out      (h_out),
        .swap_cnt   (swap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] model_h();
        logic [CW-1:0] v;
        int t;
        for (int i = 0; i < NS; i++) begin
            t = model_active[i];
            v[CW-1-i*DW -: DW] = t[DW-1:0];
        end
        return v;
    endfunction

    task automatic check_wide(input string nm, input logic [CW-1:0] exp);
        checks++;
        if (h_out !== exp) begin
            failures++;
            for (int i = 0; i < NS; i++) begin
                if (h_out[CW-1-i*DW -: DW] !== exp[CW-1-i*DW -: DW]) begin
                    $display("FAIL %s: tap %0d got %0h expected %0h at %0t", nm, i,
                             h_out[CW-1-i*DW -: DW], exp[CW-1-i*DW -: DW], $time);
                    break;
                end
            end
        end
    endtask

    function automatic int tap(input int i);
        logic signed [DW-1:0] v;
        v = h_out[CW-1-i*DW -: DW];
        return int'(v);
    endfunction

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return src_req;
            1:       return flt_in_ack;
            default: return cfg.cfg_ack;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic v, input string nm);
        int k = 0;
        while (sig_of(sel) !== v && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(nm, sig_of(sel), v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            model_shadow[i] = 0;
            model_active[i] = 0;
        end
        model_swaps = 0;
        model_err   = 1'b0;
    endtask

    // One complete 4-phase config transaction; lat counts edges from the sampling edge to cfg_ack high.
    task automatic cfg_xact(input bit commit, input int addr, input int data, output int lat);
        @(negedge clk);
        cfg.cfg_req    = 1'b1;
        cfg.cfg_commit = commit;
        cfg.cfg_addr   = addr[AW-1:0];
        cfg.cfg_data   = data[DW-1:0];
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!cfg.cfg_ack && lat < 300);
        check("cfg_ack_rise", cfg.cfg_ack, 1'b1);
        if (commit) begin
            for (int i = 0; i < NS; i++) model_active[i] = model_shadow[i];
            model_swaps++;
        end else if (addr < NS) begin
            model_shadow[addr] = data;
        end else begin
            model_err = 1'b1;
        end
        @(negedge clk);
        cfg.cfg_req    = 1'b0;
        cfg.cfg_commit = 1'b0;
        wait_for(2, 1'b0, "cfg_ack_fall");
    endtask

    task automatic xfer_tail(input int hold);
        @(negedge clk) src_ack = 1'b1;
        wait_for(1, 1'b1, "xfer_flt_ack_rise");
        @(negedge clk) flt_in_req = 1'b0;
        wait_for(0, 1'b0, "xfer_src_req_fall");
        repeat (hold) @(negedge clk);
        @(negedge clk) src_ack = 1'b0;
    endtask

    task automatic xfer(input int dly, input int hold);
        @(negedge clk) flt_in_req = 1'b1;
        wait_for(0, 1'b1, "xfer_src_req_rise");
        repeat (dly) @(negedge clk);
        xfer_tail(hold);
    endtask

    // Coefficients must not move while a sample transfer is open, and no request may start over a held src_ack.
    initial begin
        logic [CW-1:0] h_win;
        bit prev_win = 1'b0;
        bit prev_req = 1'b0;
        bit win;
        h_win = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                prev_win = 1'b0;
                prev_req = 1'b0;
            end else begin
                win = src_req || src_ack;
                if (win && prev_win) check_wide("mon_h_stable_in_xfer", h_win);
                if (win && !prev_win) h_win = h_out;
                if (src_req && !prev_req) check("mon_req_rise_ack_low", src_ack, 1'b0);
                prev_win = win;
                prev_req = src_req;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int lat;
        logic [CW-1:0] h_before;

        vecs[0] = '{1'b0,  5,   1024, 1, 1'b0, 0};
        vecs[1] = '{1'b0, 14,   4096, 1, 1'b0, 0};
        vecs[2] = '{1'b1,  0,      0, 3, 1'b0, 1};
        vecs[3] = '{1'b0,  0,     -1, 1, 1'b0, 1};
        vecs[4] = '{1'b0, 31,  32767, 1, 1'b0, 1};
        vecs[5] = '{1'b0, 40,      7, 1, 1'b1, 1};
        vecs[6] = '{1'b1,  0,      0, 3, 1'b1, 2};
        vecs[7] = '{1'b0, 31, -32768, 1, 1'b1, 2};
        vecs[8] = '{1'b1,  0,      0, 3, 1'b1, 3};

        rst            = 1'b1;
        flt_in_req     = 1'b0;
        src_ack        = 1'b0;
        cfg.cfg_req    = 1'b0;
        cfg.cfg_commit = 1'b0;
        cfg.cfg_addr   = '0;
        cfg.cfg_data   = '0;
        model_reset();

        #100;
        check_wide("rst_h_out", '0);
        check("rst_cfg_ack", cfg.cfg_ack, 1'b0);
        check("rst_cfg_err", cfg.cfg_err, 1'b0);
        check("rst_src_req", src_req, 1'b0);
        check("rst_flt_in_ack", flt_in_ack, 1'b0);
        check("rst_swap_cnt", swap_cnt, 8'd0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_no_src_req", src_req, 1'b0);
        check("post_rst_swap_cnt", swap_cnt, 8'd0);

        // Table of writes and commits with the sample side idle.
        for (int v = 0; v < 9; v++) begin
            cfg_xact(vecs[v].commit, vecs[v].addr, vecs[v].data, lat);
            check($sformatf("vec%0d_ack_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_cfg_err", v), cfg.cfg_err, vecs[v].exp_err);
            check($sformatf("vec%0d_swap_cnt", v), swap_cnt, vecs[v].exp_swaps);
            check_wide($sformatf("vec%0d_h_out", v), model_h());
            if (v == 2) begin
                check("tap5_after_commit", tap(5), 1024);
                check("tap14_after_commit", tap(14), 4096);
                check("tap8_still_zero", tap(8), 0);
            end
        end

        // Commit issued mid-transfer with src_ack delayed 6 cycles.
        cfg_xact(1'b0, 3, 777, lat);
        h_before = h_out;
        @(negedge clk) flt_in_req = 1'b1;
        @(posedge clk);
        #1;
        check("defer_src_req_latency", src_req, 1'b1);
        @(negedge clk);
        cfg.cfg_req    = 1'b1;
        cfg.cfg_commit = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check_wide("defer_h_hold_fwd", h_before);
            check("defer_no_ack_fwd", cfg.cfg_ack, 1'b0);
        end
        @(negedge clk) src_ack = 1'b1;
        @(posedge clk);
        #1;
        check("defer_flt_ack_latency", flt_in_ack, 1'b1);
        @(negedge clk) flt_in_req = 1'b0;
        @(posedge clk);
        #1;
        check("defer_flt_ack_fall_latency", flt_in_ack, 1'b0);
        check("defer_src_req_fall", src_req, 1'b0);
        @(negedge clk) flt_in_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("defer_no_req_while_pending", src_req, 1'b0);
            check_wide("defer_h_hold_rel", h_before);
        end
        @(negedge clk) src_ack = 1'b0;
        @(posedge clk);
        #1;
        check_wide("defer_h_before_swap", h_before);
        check("defer_no_req_swap_entry", src_req, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) model_active[i] = model_shadow[i];
        model_swaps++;
        check_wide("defer_h_swapped", model_h());
        check("defer_tap3", tap(3), 777);
        check("defer_cfg_ack", cfg.cfg_ack, 1'b1);
        check("defer_swap_cnt", swap_cnt, model_swaps);
        check("defer_no_req_in_swap", src_req, 1'b0);
        @(posedge clk);
        #1;
        check("defer_req_after_swap", src_req, 1'b1);
        @(negedge clk);
        cfg.cfg_req    = 1'b0;
        cfg.cfg_commit = 1'b0;
        xfer_tail(0);
        wait_for(2, 1'b0, "defer_cfg_ack_fall");

        // Source keeps src_ack high 5 cycles past src_req falling while the filter asks again.
        @(negedge clk) flt_in_req = 1'b1;
        wait_for(0, 1'b1, "hold_src_req_rise");
        @(negedge clk) src_ack = 1'b1;
        wait_for(1, 1'b1, "hold_flt_ack_rise");
        @(negedge clk) flt_in_req = 1'b0;
        wait_for(0, 1'b0, "hold_src_req_fall");
        @(negedge clk) flt_in_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("hold_no_req_while_ack", src_req, 1'b0);
        end
        @(negedge clk) src_ack = 1'b0;
        @(posedge clk);
        #1;
        check("hold_req_not_yet", src_req, 1'b0);
        @(posedge clk);
        #1;
        check("hold_req_one_cycle_after", src_req, 1'b1);
        xfer_tail(0);

        // Asynchronous reset with the sample FSM in S_ACK and a commit pending.
        @(negedge clk) flt_in_req = 1'b1;
        wait_for(0, 1'b1, "rstx_src_req_rise");
        @(negedge clk) src_ack = 1'b1;
        wait_for(1, 1'b1, "rstx_flt_ack_rise");
        @(negedge clk);
        cfg.cfg_req    = 1'b1;
        cfg.cfg_commit = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rstx_flt_ack_async", flt_in_ack, 1'b0);
        check("rstx_src_req_async", src_req, 1'b0);
        flt_in_req     = 1'b0;
        src_ack        = 1'b0;
        cfg.cfg_req    = 1'b0;
        cfg.cfg_commit = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_wide("rstx_h_zero", '0);
        check("rstx_cfg_err", cfg.cfg_err, 1'b0);
        @(negedge clk) rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rstx_no_swap", swap_cnt, 8'd0);
        check("rstx_no_ack", cfg.cfg_ack, 1'b0);
        check("rstx_no_req", src_req, 1'b0);
        check_wide("rstx_h_still_zero", '0);

        // Randomized host traffic racing randomized sample transfers.
        fork
            begin
                int rl;
                int a;
                for (int n = 0; n < 30; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        cfg_xact(1'b1, 0, 0, rl);
                        check_wide("rnd_h_after_commit", model_h());
                        check("rnd_swap_cnt", swap_cnt, model_swaps);
                    end else begin
                        a = int'($urandom_range(0, NS - 1));
                        cfg_xact(1'b0, a, int'($urandom_range(0, 65535)) - 32768, rl);
                    end
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                for (int n = 0; n < 30; n++) begin
                    xfer(int'($urandom_range(0, 8)), int'($urandom_range(0, 4)));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        cfg_xact(1'b1, 0, 0, lat);
        check_wide("rnd_final_h", model_h());
        check("rnd_final_swap_cnt", swap_cnt, model_swaps);
        check("rnd_final_cfg_err", cfg.cfg_err, model_err);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
